path_delay_meter: RTL
=====================

// Module: path_delay_meter
// PURPOSE
//  Downstream observer for a single-bit pin-to-pin delay cell with a 2-unit a=>y path delay.
//  Samples the cell's input (a_in) and output (y_in) on clk and measures a->y latency in clk cycles.
//  Each measured edge gets a latency count and polarity; timeouts and unexplained y edges are flagged.
//  Sits in the delay-cell testbench/characterisation path; feeds a scoreboard or $monitor logger.
// PARAMETERS
//  SYNC_STAGES  2    flops per input synchroniser (>=2)
//  CNT_W        8    width of latency counter and meas_cycles
//  TIMEOUT      200  cycles in MEASURE before timeout fires (must be < 2**CNT_W)
// PORTS
//  clk          in   1      single clock, all logic on posedge
//  rst_n        in   1      asynchronous, active-low reset
//  enable       in   1      1 = measure; 0 = force IDLE, suppress all output pulses
//  a_in         in   1      delay-cell input (asynchronous to clk)
//  y_in         in   1      delay-cell output (asynchronous to clk)
//  busy         out  1      1 while in MEASURE
//  meas_valid   out  1      1-cycle pulse: meas_cycles/meas_rising valid
//  meas_cycles  out  CNT_W  a-edge-to-y-edge latency in clk cycles (held until next valid)
//  meas_rising  out  1      1 = measured edge was rising, 0 = falling
//  timeout      out  1      1-cycle pulse: no matching y edge within TIMEOUT cycles
//  spurious     out  1      1-cycle pulse: y edge with no pending a edge of same polarity
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, sync/prev flops=0, all outputs 0.
//  Sync+edge: each input passes SYNC_STAGES flops then a prev flop; edge = sync^prev, pol = sync.
//   Edge seen SYNC_STAGES+1 cycles after pin change; equal on both paths, so latency is unbiased.
//  FSM states IDLE, MEASURE (2-bit encoding from package):
//   IDLE: a_edge & enable -> MEASURE, cnt<=0, exp_pol<=a_pol.
//         y_edge with no a_edge -> spurious pulse, stay IDLE.
//         a_edge & y_edge same cycle, same polarity -> meas_valid, meas_cycles=0, stay IDLE.
//   MEASURE: cnt increments by 1 per cycle, no wrap.
//         y_edge & y_pol==exp_pol -> meas_valid next cycle, meas_cycles=cnt+1, meas_rising=exp_pol, ->IDLE.
//         y_edge & y_pol!=exp_pol -> spurious pulse, stay MEASURE, cnt keeps counting.
//         a_edge, no matching y_edge -> restart: cnt<=0, exp_pol<=a_pol (pulse narrower than path delay;
//           cell filters it, so no y edge is expected for the old edge).
//         matching y_edge and a_edge same cycle -> report current measurement, then restart
//           MEASURE with cnt<=0, exp_pol<=a_pol (back-to-back edges).
//         cnt==TIMEOUT-1 with no y_edge -> timeout pulse, ->IDLE, meas_* unchanged.
//  Output pulses are registered: asserted exactly one cycle after the causing edge-detect cycle.
//  meas_cycles/meas_rising hold their last value between valid pulses.
//  enable=0: next cycle state=IDLE, cnt=0, no pulses; synchronisers keep running so no false edge
//   appears when enable returns to 1.
//  rst_n low mid-MEASURE: immediate return to reset values; no partial result is reported.
//  Latency unit: meas_cycles = number of posedges from a-edge detect to y-edge detect.
// STRUCTURE
//  Package path_delay_pkg: state typedef (IDLE, MEASURE), default CNT_W/TIMEOUT localparams.
//  Sub-module sync_edge_det (instantiated twice, for a_in and y_in): SYNC_STAGES synchroniser +
//   prev flop; outputs edge, pol. Top holds FSM, counter and output registers.
// TESTING (clk period 1 ns, cell delay 2 ns unless stated)
//  1 reset: rst_n=0 with a_in toggling -> all outputs 0, busy 0; release -> no pulse on first edge-free cycles.
//  2 a 0->1 at t=5, y follows +2 ns -> one meas_valid, meas_cycles=2, meas_rising=1; a 1->0 -> cycles=2, rising=0.
//  3 y_in tied 0, a toggles 0->1 -> busy for 200 cycles, timeout pulse once, meas_valid never.
//  4 y_in toggles with a_in static -> spurious pulse per y edge, busy stays 0.
//  5 a pulse 1 ns wide (cell swallows it) then a 0->1 held -> restart; single meas_valid, cycles=2, rising=1.
//  6 rst_n asserted 1 cycle into MEASURE -> busy drops async, no meas_valid/timeout; enable=0 mid-MEASURE -> same, no pulses.

Source files
------------

// File: rtl/path_delay_pkg.sv
// Shared types and default sizing for the path delay meter.
package path_delay_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1
   } state_t;

   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_CNT_W       = 8;
   localparam int DEF_TIMEOUT     = 200;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser plus previous-value flop; reports any transition
// of the synchronised input and its new level.
module sync_edge_det #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic edge_pulse,
   output logic pol
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // NOTE: every flop here is sequential state, so non-blocking assignments
   // keep the shift chain from collapsing into a single stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign pol        = sync_q[SYNC_STAGES-1];
   assign edge_pulse = pol ^ prev_q;

endmodule

// File: rtl/path_delay_meter.sv
// Measures a_in -> y_in edge latency of a delay cell in clk cycles, flagging
// timeouts and y edges that no pending a edge explains.
module path_delay_meter
   import path_delay_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int CNT_W       = DEF_CNT_W,
   parameter int TIMEOUT     = DEF_TIMEOUT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             a_in,
   input  logic             y_in,
   output logic             busy,
   output logic             meas_valid,
   output logic [CNT_W-1:0] meas_cycles,
   output logic             meas_rising,
   output logic             timeout,
   output logic             spurious
);

   logic       a_edge, a_pol, y_edge, y_pol;
   logic       y_match;
   logic       exp_pol;
   state_t     state;
   logic [CNT_W-1:0] cnt;

   // Identical synchroniser depth on both paths cancels out of the latency.
   sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_a_det (
      .clk(clk), .rst_n(rst_n), .din(a_in), .edge_pulse(a_edge), .pol(a_pol)
   );

   sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_y_det (
      .clk(clk), .rst_n(rst_n), .din(y_in), .edge_pulse(y_edge), .pol(y_pol)
   );

   assign y_match = y_edge && (y_pol == exp_pol);
   assign busy    = (state == MEASURE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         exp_pol     <= 1'b0;
         meas_valid  <= 1'b0;
         meas_cycles <= '0;
         meas_rising <= 1'b0;
         timeout     <= 1'b0;
         spurious    <= 1'b0;
      end else begin
         // NOTE: pulses default low every cycle so each one lasts exactly one
         // clock; meas_cycles/meas_rising are deliberately not defaulted.
         meas_valid <= 1'b0;
         timeout    <= 1'b0;
         spurious   <= 1'b0;
         if (!enable) begin
            state <= IDLE;
            cnt   <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (a_edge && y_edge && (a_pol == y_pol)) begin
                     meas_valid  <= 1'b1;
                     meas_cycles <= '0;
                     meas_rising <= a_pol;
                  end else begin
                     if (y_edge) spurious <= 1'b1;
                     if (a_edge) begin
                        state   <= MEASURE;
                        cnt     <= '0;
                        exp_pol <= a_pol;
                     end
                  end
               end
               MEASURE: begin
                  if (y_match) begin
                     meas_valid  <= 1'b1;
                     meas_cycles <= cnt + CNT_W'(1);
                     meas_rising <= exp_pol;
                  end else if (y_edge) begin
                     spurious <= 1'b1;
                  end
                  // A new a edge always restarts, whether or not it also closed a measurement.
                  if (a_edge) begin
                     cnt     <= '0;
                     exp_pol <= a_pol;
                  end else if (y_match) begin
                     state <= IDLE;
                     cnt   <= '0;
                  end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                     timeout <= 1'b1;
                     state   <= IDLE;
                     cnt     <= '0;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               default: begin
                  state <= IDLE;
                  cnt   <= '0;
               end
            endcase
         end
      end
   end

endmodule
